mv_pattern1_check: RTL and testbench

Receive-side checker for the eight-band horizontal colour-bar video stream (white, yellow, cyan, green, magenta, red, blue, black, top to bottom). It sits on the hs/vs/de/rgb bus after the pattern source, or after an HDMI receive path, in the same pixel-clock domain. Per frame it measures active geometry, checks every active pixel against the expected band colour, and reports per-frame pass/fail, a saturating error count and a lock flag for board-level loopback tests.

---
 rtl/mv_pattern_pkg.sv | 35 +++
 rtl/mv_band_tracker.sv | 45 ++++
 rtl/mv_pattern1_check.sv | 162 ++++++++++++++++
 tb/tb_mv_pattern1_check.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mv_pattern_pkg.sv
// Shared definitions for the eight-band colour-bar source and its receive-side checker.
package mv_pattern_pkg;

    localparam int BAND_NUM  = 8;
    localparam int BAND_LOG2 = 3;

    localparam logic [23:0] RGB_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] RGB_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] RGB_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] RGB_RED     = 24'hFF_00_00;
    localparam logic [23:0] RGB_BLUE    = 24'h00_00_FF;
    localparam logic [23:0] RGB_BLACK   = 24'h00_00_00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2
    } chk_state_e;

    function automatic logic [23:0] band_rgb(input logic [BAND_LOG2-1:0] band);
        case (band)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/mv_band_tracker.sv
// Expected colour band for the current row, stepping at multiples of ref_vactive/8 without a divider.
module mv_band_tracker
    import mv_pattern_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start_i,
    input  logic [15:0]          y_cnt_i,
    input  logic [15:0]          ref_vactive_i,
    output logic [BAND_LOG2-1:0] band_o
);

    logic [15:0]          band_w_q;
    logic [15:0]          next_q;
    logic [BAND_LOG2-1:0] band_q;
    logic                 adv;

    // Combinational look-ahead so a pixel right after a line end already sees the new band.
    assign adv = (y_cnt_i == next_q) && (band_q != BAND_LOG2'(BAND_NUM - 1));

    always_comb begin
        band_o = band_q;
        if (frame_start_i) begin
            band_o = '0;
        end else if (adv) begin
            band_o = band_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            band_w_q <= '0;
            next_q   <= '0;
            band_q   <= '0;
        end else if (frame_start_i) begin
            band_w_q <= ref_vactive_i >> BAND_LOG2;
            next_q   <= ref_vactive_i >> BAND_LOG2;
            band_q   <= '0;
        end else if (adv) begin
            band_q <= band_q + 1'b1;
            next_q <= next_q + band_w_q;
        end
    end

endmodule

// File: rtl/mv_pattern1_check.sv
// Colour-bar stream checker: measures geometry, checks every active pixel, reports per-frame pass and lock.
module mv_pattern1_check
    import mv_pattern_pkg::*;
#(
    parameter logic        VS_POL      = 1'b1,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [7:0]  rgb_r,
    input  logic [7:0]  rgb_g,
    input  logic [7:0]  rgb_b,
    output logic [15:0] meas_hactive,
    output logic [15:0] meas_vactive,
    output logic [15:0] frame_cnt,
    output logic [31:0] err_cnt,
    output logic        frame_done,
    output logic        frame_pass,
    output logic        geom_err,
    output logic        lock
);

    localparam logic [15:0] MAX16 = 16'hFFFF;
    localparam int          RUN_W = $clog2(LOCK_FRAMES + 1);

    logic        hs_unused;
    logic        vs_d_q, vs_dd_q, de_d_q, de_dd_q;
    logic [23:0] rgb_d_q;
    chk_state_e  state_q, state_d;
    logic [15:0] x_cnt_q, y_cnt_q, first_len_q;
    logic        line_bad_q, pix_err_q;
    logic [15:0] meas_h_q, meas_v_q, frame_cnt_q;
    logic [31:0] err_cnt_q;
    logic        done_q, pass_q, geom_q;
    logic [RUN_W-1:0] run_q;

    logic        frame_start, line_end, part_line, latch;
    logic [15:0] lines_fin, hact_fin, ref_vactive;
    logic        geom_fin, same_geom, pass_fin, clean, pix_bad;
    logic [BAND_LOG2-1:0] band;

    assign hs_unused = hs;

    assign frame_start = (vs_d_q == VS_POL) && (vs_dd_q != VS_POL);
    assign line_end    = de_dd_q && !de_d_q;
    assign part_line   = (x_cnt_q != 16'd0);
    assign latch       = frame_start && (state_q != ST_IDLE);

    // Closing view of the frame: a line still open at frame start counts as a line.
    assign lines_fin = (part_line && (y_cnt_q != MAX16)) ? y_cnt_q + 16'd1 : y_cnt_q;
    assign hact_fin  = (y_cnt_q == 16'd0) ? x_cnt_q : first_len_q;
    assign geom_fin  = line_bad_q
                     | (part_line && (y_cnt_q != 16'd0) && (x_cnt_q != first_len_q))
                     | (lines_fin < 16'd8);
    assign same_geom = (hact_fin == meas_h_q) && (lines_fin == meas_v_q);
    assign pass_fin  = (state_q == ST_CHECK) && !geom_fin && !pix_err_q;
    assign clean     = pass_fin && same_geom;

    assign ref_vactive = latch ? lines_fin : meas_v_q;

    mv_band_tracker u_band (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .y_cnt_i       (y_cnt_q),
        .ref_vactive_i (ref_vactive),
        .band_o        (band)
    );

    assign pix_bad = (state_d == ST_CHECK) && de_d_q && (rgb_d_q != band_rgb(band));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_MEASURE;
            ST_MEASURE: if (frame_start && (lines_fin >= 16'd8)) state_d = ST_CHECK;
            ST_CHECK:   if (frame_start && !same_geom) state_d = ST_MEASURE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d_q      <= ~VS_POL;
            vs_dd_q     <= ~VS_POL;
            de_d_q      <= 1'b0;
            de_dd_q     <= 1'b0;
            rgb_d_q     <= '0;
            state_q     <= ST_IDLE;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            first_len_q <= '0;
            line_bad_q  <= 1'b0;
            pix_err_q   <= 1'b0;
            meas_h_q    <= '0;
            meas_v_q    <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            geom_q      <= 1'b0;
            run_q       <= '0;
        end else begin
            vs_d_q  <= vs;
            vs_dd_q <= vs_d_q;
            de_d_q  <= de;
            de_dd_q <= de_d_q;
            rgb_d_q <= {rgb_r, rgb_g, rgb_b};
            state_q <= state_d;

            if (frame_start) begin
                x_cnt_q     <= de_d_q ? 16'd1 : 16'd0;
                y_cnt_q     <= '0;
                first_len_q <= '0;
                line_bad_q  <= 1'b0;
                pix_err_q   <= pix_bad;
            end else begin
                pix_err_q <= pix_err_q | pix_bad;
                if (line_end) begin
                    x_cnt_q <= '0;
                    if (y_cnt_q != MAX16) y_cnt_q <= y_cnt_q + 16'd1;
                    if (y_cnt_q == 16'd0) begin
                        first_len_q <= x_cnt_q;
                    end else if (x_cnt_q != first_len_q) begin
                        line_bad_q <= 1'b1;
                    end
                end else if (de_d_q && (x_cnt_q != MAX16)) begin
                    x_cnt_q <= x_cnt_q + 16'd1;
                end
            end

            if (pix_bad && (err_cnt_q != 32'hFFFF_FFFF)) err_cnt_q <= err_cnt_q + 32'd1;

            done_q <= latch;
            if (latch) begin
                meas_h_q    <= hact_fin;
                meas_v_q    <= lines_fin;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                pass_q      <= pass_fin;
                geom_q      <= geom_fin;
                if (!clean) begin
                    run_q <= '0;
                end else if (run_q != RUN_W'(LOCK_FRAMES)) begin
                    run_q <= run_q + 1'b1;
                end
            end
        end
    end

    assign meas_hactive = meas_h_q;
    assign meas_vactive = meas_v_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign frame_done   = done_q;
    assign frame_pass   = pass_q;
    assign geom_err     = geom_q;
    assign lock         = (run_q == RUN_W'(LOCK_FRAMES));

endmodule

// File: tb/tb_mv_pattern1_check.sv
// Scoreboard bench: a frame-level model pushes expected results at each frame start, checked at frame_done.
module tb_mv_pattern1_check;

    localparam int LOCKN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [7:0]  rgb_r = '0, rgb_g = '0, rgb_b = '0;
    logic [15:0] meas_hactive, meas_vactive, frame_cnt;
    logic [31:0] err_cnt;
    logic        frame_done, frame_pass, geom_err, lock;

    mv_pattern1_check #(.VS_POL(1'b1), .LOCK_FRAMES(LOCKN)) dut (
        .clk          (clk),
        .rst          (rst),
        .hs           (hs),
        .vs           (vs),
        .de           (de),
        .rgb_r        (rgb_r),
        .rgb_g        (rgb_g),
        .rgb_b        (rgb_b),
        .meas_hactive (meas_hactive),
        .meas_vactive (meas_vactive),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .frame_done   (frame_done),
        .frame_pass   (frame_pass),
        .geom_err     (geom_err),
        .lock         (lock)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     h;
        int     v;
        int     fcnt;
        longint err;
        bit     pass;
        bit     geom;
        bit     lock;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // model state: 0 idle, 1 measure, 2 check
    int     m_state = 0, m_h = 0, m_v = 0, m_fcnt = 0, m_run = 0;
    longint m_err = 0;
    int     f_first = 0, f_lines = 0, f_errs = 0;
    bit     f_bad = 0;
    int     vs_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] bar(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_meas_h"}, 32'(meas_hactive), 0);
        chk({tag, "_meas_v"}, 32'(meas_vactive), 0);
        chk({tag, "_fcnt"},   32'(frame_cnt), 0);
        chk({tag, "_err"},    err_cnt, 0);
        chk({tag, "_done"},   32'(frame_done), 0);
        chk({tag, "_pass"},   32'(frame_pass), 0);
        chk({tag, "_geom"},   32'(geom_err), 0);
        chk({tag, "_lock"},   32'(lock), 0);
    endtask

    task automatic model_frame_start();
        exp_t e;
        bit   geom, pass, same;
        if (m_state != 0) begin
            geom  = f_bad || (f_lines < 8);
            pass  = (m_state == 2) && !geom && (f_errs == 0);
            same  = (f_first == m_h) && (f_lines == m_v);
            m_run = (pass && same) ? ((m_run < LOCKN) ? m_run + 1 : m_run) : 0;
            m_err = m_err + f_errs;
            if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
            m_fcnt = (m_fcnt + 1) & 16'hFFFF;
            e.h = f_first; e.v = f_lines; e.fcnt = m_fcnt; e.err = m_err;
            e.pass = pass; e.geom = geom; e.lock = (m_run == LOCKN);
            sb.push_back(e);
            if (m_state == 1 && f_lines >= 8) m_state = 2;
            else if (m_state == 2 && !same) m_state = 1;
            m_h = f_first;
            m_v = f_lines;
        end else begin
            m_state = 1;
        end
        f_first = 0; f_lines = 0; f_errs = 0; f_bad = 0;
    endtask

    task automatic vs_edge();
        @(negedge clk);
        vs = 1'b1;
        vs_cyc = cyc;
        model_frame_start();
        repeat (2) @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // short_y: line one pixel short; bad_y/bad_x: pixel forced white; rst_y: reset pulse at x=5 of that line
    task automatic drive_frame(input int hact, input int vact, input int short_y,
                               input int bad_y, input int bad_x, input int rst_y);
        int          len, gb, eb, wref;
        logic [23:0] pix;
        vs_edge();
        for (int y = 0; y < vact; y++) begin
            len = (y == short_y) ? hact - 1 : hact;
            gb  = y / (vact >> 3);
            if (gb > 7) gb = 7;
            for (int x = 0; x < len; x++) begin
                pix = bar(gb);
                if (y == bad_y && x == bad_x) pix = 24'hFFFFFF;
                de = 1'b1;
                {rgb_r, rgb_g, rgb_b} = pix;
                if (m_state == 2) begin
                    wref = m_v >> 3;
                    eb   = y / wref;
                    if (eb > 7) eb = 7;
                    if (pix != bar(eb)) f_errs++;
                end
                if (y == rst_y && x == 5) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check_zero("midrst");
                    rst = 1'b0;
                    de  = 1'b0;
                    m_state = 0; m_h = 0; m_v = 0; m_fcnt = 0; m_run = 0; m_err = 0;
                    f_first = 0; f_lines = 0; f_errs = 0; f_bad = 0;
                    repeat (6) @(negedge clk);
                    return;
                end
                @(negedge clk);
            end
            de = 1'b0;
            hs = 1'b1;
            repeat (2) @(negedge clk);
            hs = 1'b0;
            repeat (1) @(negedge clk);
            if (f_lines == 0) f_first = len;
            else if (len != f_first) f_bad = 1'b1;
            f_lines++;
        end
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(frame_done), 0);
            end else begin
                e = sb.pop_front();
                chk("done_latency", 32'(cyc - vs_cyc), 2);
                chk("meas_h",    32'(meas_hactive), 32'(e.h));
                chk("meas_v",    32'(meas_vactive), 32'(e.v));
                chk("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
                chk("err_cnt",   err_cnt, 32'(e.err));
                chk("pass",      32'(frame_pass), 32'(e.pass));
                chk("geom_err",  32'(geom_err), 32'(e.geom));
                chk("lock",      32'(lock), 32'(e.lock));
            end
        end
    end

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: got no finish by cycle %0d expected under 200000", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 40x24 bars: W=3, lock at the fifth frame_done
        repeat (6) drive_frame(40, 24, -1, -1, -1, -1);
        // one yellow-band pixel forced white, then recovery
        drive_frame(40, 24, -1, 4, 7, -1);
        repeat (4) drive_frame(40, 24, -1, -1, -1, -1);
        // shortened line: geometry error without pixel errors
        drive_frame(40, 24, 10, -1, -1, -1);
        drive_frame(40, 24, -1, -1, -1, -1);
        // 31 lines: W=3, rows 21..30 all black
        repeat (4) drive_frame(40, 31, -1, -1, -1, -1);
        // resolution switch, then relock
        repeat (7) drive_frame(20, 16, -1, -1, -1, -1);
        // reset in the middle of an active line, then resume
        drive_frame(20, 16, -1, -1, -1, 3);
        repeat (3) drive_frame(20, 16, -1, -1, -1, -1);
        vs_edge();
        repeat (10) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
